// File: rtl/carr_pkg.sv
// Shared types and constants for the carriage brush sequencer.
// Skip FSM states, default channel count, bad-code value, width helper.
package carr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      STOP = 2'd2
   } carr_state_t;

   localparam int CARR_NCH_DEFAULT = 12;

   // All-ones code; callers take the low OW bits.
   localparam logic [15:0] CARR_CODE_BAD = 16'hFFFF;

   // Encode width: enough bits to hold 0..n.
   function automatic int carr_ow(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/carr_brush_enc.sv
// Combinational brush encoder: right-most (highest-numbered) channel wins.
// Ports: brush {ch1..chNCH} in; chan (0 = no hole) and multi (>=2 bits) out.
module carr_brush_enc
   import carr_pkg::*;
#(
   parameter int NCH = CARR_NCH_DEFAULT,
   parameter int OW  = carr_ow(NCH)
) (
   input  logic [NCH-1:0] brush,
   output logic [OW-1:0]  chan,
   output logic           multi
);

   // Channel k sits at bit NCH-k; the lowest set bit is the highest
   // channel, so scanning downward lets it overwrite earlier hits.
   always_comb begin
      chan = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (brush[i]) chan = OW'(NCH - i);
      end
   end

   // Clearing the lowest set bit leaves something only if >= 2 were set.
   assign multi = |(brush & (brush - NCH'(1)));

endmodule

// File: rtl/carr_brush_seq.sv
// Carriage brush sampler/debouncer, encoder, valid/ack port, skip sequencer.
// Ports: i_clk, i_reset (async high), i_brush, i_strobe, i_ack, i_skip,
//   i_target, i_abort; o_chan, o_valid, o_overrun, o_slow, o_stop,
//   o_busy, o_multi. Macro CARR_MULTI_ERR_EN flags multi-hole patterns.
module carr_brush_seq
   import carr_pkg::*;
#(
   parameter int NCH = CARR_NCH_DEFAULT,
   parameter int OW  = carr_ow(NCH),
   parameter int DEB = 2
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic [NCH-1:0] i_brush,
   input  logic           i_strobe,
   input  logic           i_ack,
   input  logic           i_skip,
   input  logic [OW-1:0]  i_target,
   input  logic           i_abort,
   output logic [OW-1:0]  o_chan,
   output logic           o_valid,
   output logic           o_overrun,
   output logic           o_slow,
   output logic           o_stop,
   output logic           o_busy,
   output logic           o_multi
);

   localparam logic [3:0]    DEB_C  = 4'(DEB);
   localparam logic [3:0]    DEB_M1 = 4'(DEB - 1);
   localparam logic [OW-1:0] NCH_C  = OW'(NCH);
   localparam logic [OW-1:0] ONE_C  = OW'(1);

   logic [NCH-1:0] snap_q;
   logic [3:0]     cnt_q;
   logic           same;
   logic           accept;

   logic [OW-1:0]  enc_chan;
   logic           enc_multi;
   logic [OW-1:0]  code;
   logic           bad;

   logic [OW-1:0]  chan_q;
   logic           valid_q;
   logic           over_q;

   carr_state_t    state_q, state_nxt;
   logic [OW-1:0]  tgt_q, tgt_nxt;
   logic           slow_q, slow_nxt;
   logic [OW-1:0]  tgt_m1;
   logic           tgt_ok;

   // Debounce: accept only on the strobe where the run length first
   // reaches DEB; saturation blocks a second accept of the same run.
   assign same   = (i_brush == snap_q);
   assign accept = i_strobe &&
                   (same ? (cnt_q == DEB_M1) : (DEB_C == 4'd1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         snap_q <= '0;
         cnt_q  <= '0;
      end else if (i_strobe) begin
         if (!same) begin
            snap_q <= i_brush;
            cnt_q  <= 4'd1;
         end else if (cnt_q < DEB_C) begin
            cnt_q  <= cnt_q + 4'd1;
         end
      end
   end

   carr_brush_enc #(
      .NCH (NCH),
      .OW  (OW)
   ) u_enc (
      .brush (i_brush),
      .chan  (enc_chan),
      .multi (enc_multi)
   );

`ifdef CARR_MULTI_ERR_EN
   logic mult_q;

   assign bad  = enc_multi;
   assign code = bad ? CARR_CODE_BAD[OW-1:0] : enc_chan;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)     mult_q <= 1'b0;
      else if (accept) mult_q <= enc_multi;
   end

   assign o_multi = o_valid & mult_q;
`else
   logic multi_unused;

   assign multi_unused = enc_multi;
   assign bad          = 1'b0;
   assign code         = enc_chan;
   assign o_multi      = 1'b0;
`endif

   // Output port: a same-cycle ack never drops a freshly loaded code.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         chan_q  <= '0;
         valid_q <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         if (accept) begin
            chan_q  <= code;
            valid_q <= 1'b1;
            if (valid_q && !i_ack) over_q <= 1'b1;
         end else if (i_ack) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_chan    = chan_q;
   assign o_valid   = valid_q;
   assign o_overrun = over_q;

   // Skip sequencer.
   assign tgt_ok = (i_target != '0) && (i_target <= NCH_C);
   assign tgt_m1 = tgt_q - ONE_C;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         slow_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         tgt_q   <= tgt_nxt;
         slow_q  <= slow_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      tgt_nxt   = tgt_q;
      slow_nxt  = slow_q;
      unique case (state_q)
         IDLE: begin
            slow_nxt = 1'b0;
            if (i_skip && tgt_ok) begin
               state_nxt = SKIP;
               tgt_nxt   = i_target;
            end
         end
         SKIP: begin
            if (i_abort) begin
               state_nxt = IDLE;
               slow_nxt  = 1'b0;
            end else if (i_skip) begin
               // Restart hides any same-cycle accept from the new target.
               if (tgt_ok) begin
                  tgt_nxt  = i_target;
                  slow_nxt = 1'b0;
               end
            end else if (accept && !bad) begin
               if (code == tgt_q) begin
                  state_nxt = STOP;
                  slow_nxt  = 1'b0;
               end else if (tgt_q > ONE_C && code == tgt_m1) begin
                  slow_nxt  = 1'b1;
               end
            end
         end
         STOP: begin
            state_nxt = IDLE;
            slow_nxt  = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            slow_nxt  = 1'b0;
         end
      endcase
   end

   assign o_slow = slow_q;
   assign o_stop = (state_q == STOP);
   assign o_busy = (state_q == SKIP);

endmodule

// File: tb/tb_carr_brush_seq.sv
// Directed bench for carr_brush_seq (NCH=12, OW=4, DEB=2).
// Checks debounce, handshake, skip sequencing, async reset, multi-hole.
module tb_carr_brush_seq;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [11:0] i_brush = '0;
   logic        i_strobe = 1'b0;
   logic        i_ack = 1'b0;
   logic        i_skip = 1'b0;
   logic [3:0]  i_target = '0;
   logic        i_abort = 1'b0;
   logic [3:0]  o_chan;
   logic        o_valid;
   logic        o_overrun;
   logic        o_slow;
   logic        o_stop;
   logic        o_busy;
   logic        o_multi;

   int nvec = 0;
   int nbad = 0;

   carr_brush_seq #(
      .NCH (12),
      .OW  (4),
      .DEB (2)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_brush   (i_brush),
      .i_strobe  (i_strobe),
      .i_ack     (i_ack),
      .i_skip    (i_skip),
      .i_target  (i_target),
      .i_abort   (i_abort),
      .o_chan    (o_chan),
      .o_valid   (o_valid),
      .o_overrun (o_overrun),
      .o_slow    (o_slow),
      .o_stop    (o_stop),
      .o_busy    (o_busy),
      .o_multi   (o_multi)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [11:0] b);
      @(negedge i_clk);
      i_brush  = b;
      i_strobe = 1'b1;
      @(negedge i_clk);
      i_strobe = 1'b0;
   endtask

   task automatic ack();
      @(negedge i_clk);
      i_ack = 1'b1;
      @(negedge i_clk);
      i_ack = 1'b0;
   endtask

   task automatic skip(input logic [3:0] t, input logic ab);
      @(negedge i_clk);
      i_skip   = 1'b1;
      i_target = t;
      i_abort  = ab;
      @(negedge i_clk);
      i_skip   = 1'b0;
      i_abort  = 1'b0;
   endtask

   // {chan, valid, overrun, slow, stop, busy, multi}
   function automatic logic [15:0] outs();
      return 16'({o_chan, o_valid, o_overrun, o_slow, o_stop, o_busy,
                  o_multi});
   endfunction

   initial begin
      #3;
      chk("reset_outs", outs(), 16'h0);
      @(negedge i_clk);
      i_reset = 1'b0;

      // Debounce: channel 10 needs two strobes.
      strobe(12'h004);
      chk("deb_one_strobe", 16'(o_valid), 16'h0);
      strobe(12'h004);
      chk("deb_chan10", 16'(o_chan), 16'd10);
      chk("deb_valid", 16'(o_valid), 16'h1);
      strobe(12'h004);
      chk("deb_no_reaccept", 16'(o_valid), 16'h1);
      ack();
      chk("ack_clears", 16'(o_valid), 16'h0);

      // A change after one strobe restarts the run.
      strobe(12'h010);
      strobe(12'h020);
      chk("deb_change", 16'(o_valid), 16'h0);
      strobe(12'h020);
      chk("deb_chan7", 16'(o_chan), 16'd7);
      ack();

      // Overrun: channel 1 then channel 12 with no ack.
      strobe(12'h800);
      strobe(12'h800);
      chk("ovr_chan1", 16'(o_chan), 16'd1);
      chk("ovr_not_yet", 16'(o_overrun), 16'h0);
      strobe(12'h001);
      strobe(12'h001);
      chk("ovr_chan12", 16'(o_chan), 16'd12);
      chk("ovr_set", 16'(o_overrun), 16'h1);
      ack();
      chk("ovr_ack_valid", 16'(o_valid), 16'h0);
      chk("ovr_sticky", 16'(o_overrun), 16'h1);

      // Skip to channel 5 via 3, 4, 5.
      skip(4'd5, 1'b0);
      chk("skip_busy", 16'(o_busy), 16'h1);
      strobe(12'h200);
      strobe(12'h200);
      chk("skip_ch3_slow", 16'(o_slow), 16'h0);
      ack();
      strobe(12'h100);
      strobe(12'h100);
      chk("skip_ch4_slow", 16'(o_slow), 16'h1);
      chk("skip_ch4_stop", 16'(o_stop), 16'h0);
      strobe(12'h080);
      chk("skip_ch5_half", 16'(o_stop), 16'h0);
      strobe(12'h080);
      chk("skip_stop", 16'(o_stop), 16'h1);
      chk("skip_stop_slow", 16'(o_slow), 16'h0);
      @(negedge i_clk);
      chk("skip_stop_pulse", 16'(o_stop), 16'h0);
      chk("skip_done_busy", 16'(o_busy), 16'h0);
      ack();

      // Abort beats a same-cycle restart; bad targets are ignored.
      skip(4'd5, 1'b0);
      chk("abort_pre_busy", 16'(o_busy), 16'h1);
      skip(4'd7, 1'b1);
      chk("abort_wins", 16'(o_busy), 16'h0);
      skip(4'd0, 1'b0);
      chk("tgt0_ignored", 16'(o_busy), 16'h0);
      skip(4'd13, 1'b0);
      chk("tgt13_ignored", 16'(o_busy), 16'h0);

      // Async reset mid-skip with o_slow and o_valid up.
      skip(4'd5, 1'b0);
      strobe(12'h100);
      strobe(12'h100);
      chk("rst_pre_slow", 16'(o_slow), 16'h1);
      #2 i_reset = 1'b1;
      #1 chk("rst_async_outs", outs(), 16'h0);
      #1 i_reset = 1'b0;
      strobe(12'h100);
      chk("rst_fresh_one", 16'(o_valid), 16'h0);
      strobe(12'h100);
      chk("rst_fresh_two", 16'(o_chan), 16'd4);
      ack();

      // Multi-hole pattern 12'h101 while skipping to channel 12.
      skip(4'd12, 1'b0);
      strobe(12'h101);
      strobe(12'h101);
`ifdef CARR_MULTI_ERR_EN
      chk("multi_chan", 16'(o_chan), 16'hF);
      chk("multi_flag", 16'(o_multi), 16'h1);
      chk("multi_nostop", 16'(o_stop), 16'h0);
      chk("multi_busy", 16'(o_busy), 16'h1);
`else
      chk("multi_chan", 16'(o_chan), 16'd12);
      chk("multi_flag", 16'(o_multi), 16'h0);
      chk("multi_stop", 16'(o_stop), 16'h1);
      chk("multi_busy", 16'(o_busy), 16'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
